md_unit_e: RTL and testbench

//  E-stage multiply/divide unit; consumes the D/E pipeline register outputs (operands, decoded MD op).

---
 rtl/md_unit_e_pkg.sv | 34 +++
 rtl/md_unit_e_divider.sv | 47 ++++
 rtl/md_unit_e.sv | 142 ++++++++++++++
 tb/tb_md_unit_e.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_e_pkg.sv
// ============================================================================
// Module : md_unit_e_pkg
// Brief  : Shared encodings for the E-stage multiply/divide unit
//          (MD op codes, FSM state codes).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_unit_e_pkg;

  // Decoded MD operation presented by the D/E pipeline register
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // Sequencer states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // True for the four ops that launch a multi-cycle operation
  function automatic logic is_md_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_unit_e_divider.sv
// ============================================================================
// Module : md_divider
// Brief  : Combinational 32-bit signed/unsigned divide with remainder.
//          Signed results truncate toward zero; the remainder takes the sign
//          of the dividend. A zero divisor raises div_by_zero and the
//          quotient/remainder outputs are don't-care (driven to 0).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Divide on magnitudes and re-apply signs; this keeps 0x80000000 / -1
  // well defined (magnitude 0x80000000 wraps back to 0x80000000).
  always_comb begin
    neg_a       = is_signed & dividend[31];
    neg_b       = is_signed & divisor[31];
    mag_a       = neg_a ? (32'd0 - dividend) : dividend;
    mag_b       = neg_b ? (32'd0 - divisor)  : divisor;
    div_by_zero = (divisor == 32'd0);
    q_mag       = 32'd0;
    r_mag       = 32'd0;
    if (!div_by_zero) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quotient  = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    remainder = neg_a ? (32'd0 - r_mag) : r_mag;
  end

endmodule

`default_nettype wire

// File: rtl/md_unit_e.sv
// ============================================================================
// Module : md_unit_e
// Brief  : E-stage multiply/divide unit. Launches mult/multu/div/divu,
//          holds Busy for a fixed number of cycles, then commits the result
//          into HI/LO. Also serves mfhi/mflo/mthi/mtlo.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit_e
  import md_unit_e_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MdOp_E_I,
  input  logic [31:0] RD1_E_I,
  input  logic [31:0] RD2_E_I,
  output logic        Start_MD_O,
  output logic        Busy_MD_O,
  output logic [31:0] HI_MD_O,
  output logic [31:0] LO_MD_O,
  output logic [31:0] MdOut_E_O
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] counter;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;

  logic             start;
  logic             busy;
  logic             commit;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      div_q;
  logic [31:0]      div_r;
  logic             div_zero;
  logic             div_signed;

  assign prod_s     = $signed({{32{RD1_E_I[31]}}, RD1_E_I}) *
                      $signed({{32{RD2_E_I[31]}}, RD2_E_I});
  assign prod_u     = {32'd0, RD1_E_I} * {32'd0, RD2_E_I};
  assign div_signed = (MdOp_E_I == MD_DIV);
  assign commit     = (state == ST_RUN) && (counter == CNT_W'(1));

  md_divider u_divider (
    .dividend    (RD1_E_I),
    .divisor     (RD2_E_I),
    .is_signed   (div_signed),
    .quotient    (div_q),
    .remainder   (div_r),
    .div_by_zero (div_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: leave IDLE on a start, return on the commit cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)  state_nxt = ST_RUN;
      ST_RUN:  if (commit) state_nxt = ST_IDLE;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: Busy straight from the state flop, Start/MdOut combinational
  always_comb begin
    busy      = (state == ST_RUN);
    start     = is_md_start_op(MdOp_E_I) && !busy;
    MdOut_E_O = 32'd0;
    if (MdOp_E_I == MD_MFHI) MdOut_E_O = hi;
    if (MdOp_E_I == MD_MFLO) MdOut_E_O = lo;
  end

  // Cycle counter: loaded on start, counts down to the commit cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
    end else if (start) begin
      counter <= (MdOp_E_I == MD_MULT || MdOp_E_I == MD_MULTU) ?
                 CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (commit) begin
      counter <= '0;
    end else if (busy) begin
      counter <= counter - CNT_W'(1);
    end
  end

  // Pending result captured at start; a zero divisor re-captures HI/LO so
  // the commit leaves them unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else if (start) begin
      case (MdOp_E_I)
        MD_MULT:  {pend_hi, pend_lo} <= prod_s;
        MD_MULTU: {pend_hi, pend_lo} <= prod_u;
        default: begin
          pend_hi <= div_zero ? hi : div_r;
          pend_lo <= div_zero ? lo : div_q;
        end
      endcase
    end
  end

  // HI/LO: commit from pending, or direct moves when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      hi <= pend_hi;
      lo <= pend_lo;
    end else if (!busy) begin
      if (MdOp_E_I == MD_MTHI) hi <= RD1_E_I;
      if (MdOp_E_I == MD_MTLO) lo <= RD1_E_I;
    end
  end

  assign Start_MD_O = start;
  assign Busy_MD_O  = busy;
  assign HI_MD_O    = hi;
  assign LO_MD_O    = lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit_e.sv
// ============================================================================
// Module : tb_md_unit_e
// Brief  : Scoreboard bench for md_unit_e. Stimulus pushes expected commits
//          and move-from results; a monitor pops them as the DUT presents
//          them (Busy falling edge, MFHI/MFLO in E).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit_e;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } commit_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdout;

  int total = 0;
  int bad   = 0;

  commit_t     commit_q[$];
  logic [31:0] mdout_q[$];

  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .MdOp_E_I   (op),
    .RD1_E_I    (rd1),
    .RD2_E_I    (rd2),
    .Start_MD_O (start),
    .Busy_MD_O  (busy),
    .HI_MD_O    (hi),
    .LO_MD_O    (lo),
    .MdOut_E_O  (mdout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one op in E for one cycle (driven just after the rising edge)
  task automatic step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    op  = o;
    rd1 = a;
    rd2 = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(OP_NONE, 32'd0, 32'd0);
  endtask

  task automatic expect_commit(input logic [31:0] h, input logic [31:0] l, input int n);
    commit_t c;
    c.hi  = h;
    c.lo  = l;
    c.len = n;
    commit_q.push_back(c);
  endtask

  // Monitor: sample mid-cycle, pop expectations when the DUT presents them
  initial begin : monitor
    logic prev_busy = 1'b0;
    logic abort     = 1'b0;
    int   run_cnt   = 0;
    commit_t c;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (op == OP_MFHI || op == OP_MFLO) begin
        if (mdout_q.size() == 0) begin
          check("mdout_unexpected", mdout, 32'hDEAD_BEEF);
        end else begin
          e = mdout_q.pop_front();
          check("mdout", mdout, e);
        end
      end
      if (busy) begin
        run_cnt++;
      end else if (prev_busy) begin
        if (!abort) begin
          if (commit_q.size() == 0) begin
            check("commit_unexpected", hi, 32'hDEAD_BEEF);
          end else begin
            c = commit_q.pop_front();
            check("commit_hi", hi, c.hi);
            check("commit_lo", lo, c.lo);
            check("busy_len", run_cnt, c.len);
          end
        end
        run_cnt = 0;
      end
      prev_busy = busy;
      abort     = reset;
    end
  end

  initial begin : stim
    reset = 1'b1;
    op    = OP_NONE;
    rd1   = 32'd0;
    rd2   = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_hi",    hi,    32'd0);
    check("rst_lo",    lo,    32'd0);
    check("rst_mdout", mdout, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // MULT -1 * 2
    expect_commit(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    step(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    #1 check("mult_start", {31'd0, start}, 32'd1);
    idle(6);

    // MULTU 0xFFFFFFFF * 2
    expect_commit(32'd1, 32'hFFFF_FFFE, 5);
    step(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    idle(6);

    // DIV -7 / 2
    expect_commit(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    step(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(11);

    // DIVU 7 / 2
    expect_commit(32'd1, 32'd3, 10);
    step(OP_DIVU, 32'd7, 32'd2);
    idle(11);

    // Divide by zero leaves HI/LO untouched
    step(OP_MTHI, 32'h11, 32'd0);
    step(OP_MTLO, 32'h22, 32'd0);
    expect_commit(32'h11, 32'h22, 10);
    step(OP_DIV, 32'd5, 32'd0);
    idle(11);

    // MULT 3*4; MTLO on busy cycle 2 ignored, re-issue on cycle 3 ignored,
    // MFLO on cycle 4 sees the old LO
    expect_commit(32'd0, 32'd12, 5);
    step(OP_MULT, 32'd3, 32'd4);
    step(OP_NONE, 32'd0, 32'd0);
    step(OP_MTLO, 32'h55, 32'd0);
    step(OP_MULT, 32'd9, 32'd9);
    #1 check("busy_restart_start", {31'd0, start}, 32'd0);
    mdout_q.push_back(32'h22);
    step(OP_MFLO, 32'd0, 32'd0);
    idle(3);

    // DIV overflow 0x80000000 / -1
    expect_commit(32'd0, 32'h8000_0000, 10);
    step(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(11);

    // MULT aborted by reset on busy cycle 3
    step(OP_MULT, 32'd5, 32'd5);
    idle(3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi",   hi, 32'd0);
    check("abort_lo",   lo, 32'd0);
    idle(8);
    #1;
    check("abort_late_lo", lo, 32'd0);

    // MTHI then MFHI
    step(OP_MTHI, 32'hABCD, 32'd0);
    #1 check("mthi_start", {31'd0, start}, 32'd0);
    mdout_q.push_back(32'hABCD);
    step(OP_MFHI, 32'd0, 32'd0);
    #1;
    check("mfhi_start", {31'd0, start}, 32'd0);
    check("mfhi_busy",  {31'd0, busy},  32'd0);
    idle(3);

    check("commit_q_drained", commit_q.size(), 32'd0);
    check("mdout_q_drained",  mdout_q.size(),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
